data_to_axi_packer: RTL and testbench
=====================================

# data_to_axi_packer

Packs a single-element `data_i` stream (one `data_t` per beat, per-element keep and last) into full-width `AXI4S` beats of `NUM_ELEMENTS` elements each. It is the inverse of the AXI-to-data unpacker and sits directly downstream of per-element processing stages, feeding results back onto the wide AXI datapath. Full throughput (one element per cycle) is sustained while `out.tready` is high. One completed beat can be held back under backpressure without stalling the input.

## Interface
- `data_t`, no default: element type.
- `AXI_WIDTH`, 512: output `tdata` width in bits.
- `DATA_WIDTH`, `$bits(data_t)`: element width in bits; a multiple of 8 that divides `AXI_WIDTH`.
- `NUM_ELEMENTS`, `AXI_WIDTH / DATA_WIDTH`: slots per output beat; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in`  `data_i.s`  `data_t` + keep/last/valid/ready  element input stream.
- `out`  `AXI4S.m`  `AXI_WIDTH`  packed output stream: `tdata`, `tkeep[AXI_WIDTH/8]`, `tlast`, `tvalid`, `tready`.

## Operation
- **State:**
  - assembly register: data, keep and last per slot;
  - slot counter `slot` of `$clog2(NUM_ELEMENTS)` bits;
  - `pending` flag;
  - output register: `tdata`, `tkeep`, `tlast`, `tvalid`.
- **Accept condition:** an element is accepted when `in.valid && in.ready`.
  - It is written to slot `slot`, occupying bits `[slot*DATA_WIDTH +: DATA_WIDTH]`.
  - All `DATA_WIDTH/8` keep bytes of that slot take the value of `in.keep`.
  - Elements with `keep=0` still consume a slot.
- **Beat completion:** the beat completes on an accepted element with `slot == NUM_ELEMENTS-1` or with `in.last=1`.
  - On completion, unfilled upper slots carry zero data and zero keep. `tlast` equals `in.last`.
  - `slot` returns to 0 on completion and otherwise increments by 1; it never wraps silently.
- **Transfer on completion:**
  - If the output register is empty, or is being drained this cycle (`tvalid && tready`), the completed beat loads into it and `tvalid=1` next cycle.
  - Otherwise the beat stays in the assembly register and `pending` is set.
- **While `pending=1`:**
  - `in.ready=0`.
  - On the output handshake, the assembly register moves to the output register and `pending` clears.
- **Ready rule:** `in.ready = !pending`. It is registered-state only, with no combinational path from `in.valid`, `in.last` or `out.tready`.
- **Lone last:** a `last` element with `keep=0` at slot 0 emits a beat with `tkeep=0` and `tlast=1`. It is never dropped.
- **Reset:** asserting `rst`, including mid-beat, asynchronously clears `slot`, `pending` and the output register, and discards any partial beat.
  - Reset values: `out.tvalid=0`, `out.tdata=0`, `out.tkeep=0`, `out.tlast=0`, `in.ready=1`.

## Timing
- **Latency:** an element accepted in cycle t that completes a beat gives `out.tvalid=1` in cycle t+1, provided the output register is free or draining in cycle t.
- **Throughput:**
  - 1 element/cycle with `tready` held high.
  - A partial beat closed by `last` costs no extra cycles; the next element goes to slot 0 of a new beat.
- **Output stability:** once `tvalid=1`, `tdata`, `tkeep` and `tlast` hold until the handshake.
- **Backpressure release:** after `pending` is set, `in.ready` returns to 1 in the cycle after the output handshake.
- **Simultaneous events:**
  - Output handshake and beat completion in the same cycle (`pending=0`): the new beat loads directly into the output register and `tvalid` stays 1.
  - Accept with `slot == NUM_ELEMENTS-1` and `last=1`: completes exactly one beat, with `tlast=1`.

## Structure
- The keep-expansion helper (element keep to `DATA_WIDTH/8` byte-keep bits) goes in the shared stream package, alongside the existing stream typedefs.
- Elaboration assertions:
  - `AXI_WIDTH % DATA_WIDTH == 0`
  - `DATA_WIDTH % 8 == 0`
  - `NUM_ELEMENTS >= 2`
- Single module, no sub-modules. The output register is a plain register stage inside the block.

## Test plan
All scenarios use `DATA_WIDTH=32`, `AXI_WIDTH=128` (4 slots).
- **Full beat:** send 0x11, 0x22, 0x33, 0x44, keep=1, last on the 4th, `tready=1`. Expect one beat one cycle after the 4th accept: `tdata=0x00000044_00000033_00000022_00000011`, `tkeep=0xFFFF`, `tlast=1`.
- **Partial beat:** send 0xA, 0xB, 0xC with last on the 3rd. Expect `tdata=0x00000000_0000000C_0000000B_0000000A`, `tkeep=0x0FFF`, `tlast=1`. The next element lands in slot 0.
- **Keep hole:** send 4 elements with the 2nd at keep=0. Expect `tkeep=0xFF0F`.
- **Backpressure:** hold `tready=0` and stream 8 elements, no last.
  - Expect beat 1 in the output register, beat 2 pending, `in.ready=0`.
  - Raise `tready` for one cycle: beat 1 handshakes, beat 2 appears next cycle, `in.ready=1` next cycle, no element lost or duplicated.
- **Lone zero-keep last:** at slot 0, send keep=0, last=1. Expect one beat with `tkeep=0x0000` and `tlast=1`.
- **Reset mid-beat:** accept 2 elements, pulse `rst` asynchronously. Expect `tvalid=0` immediately and no output for the discarded elements. Then send 4 new elements: they form a beat starting at slot 0.

Source files
------------

// File: rtl/data_to_axi_packer_pkg.sv
// Shared stream helpers for the element-to-AXI packer: byte-keep expansion of a
// single element keep flag.
package data_to_axi_packer_pkg;

   localparam int MAX_ELEM_BYTES = 64;

   typedef logic [MAX_ELEM_BYTES-1:0] byte_keep_t;

   // Replicates one element keep flag across the low num_bytes byte-keep bits.
   function automatic byte_keep_t expand_keep(input logic keep, input int num_bytes);
      byte_keep_t mask;
      mask = '0;
      for (int i = 0; i < MAX_ELEM_BYTES; i++) begin
         if (i < num_bytes) mask[i] = keep;
      end
      return mask;
   endfunction

endpackage

// File: rtl/data_to_axi_packer.sv
// Packs a one-element-per-beat stream into AXI4-Stream beats of NUM_ELEMENTS
// slots, with one output register stage and one pending beat for backpressure.
module data_to_axi_packer
   import data_to_axi_packer_pkg::*;
#(
   parameter type data_t       = logic [31:0],
   parameter int  AXI_WIDTH    = 512,
   parameter int  DATA_WIDTH   = $bits(data_t),
   parameter int  NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  data_t                  in_data,
   input  logic                   in_keep,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [AXI_WIDTH-1:0]   out_tdata,
   output logic [AXI_WIDTH/8-1:0] out_tkeep,
   output logic                   out_tlast,
   output logic                   out_tvalid,
   input  logic                   out_tready
);

   localparam int ELEM_BYTES = DATA_WIDTH / 8;
   localparam int KEEP_W     = AXI_WIDTH / 8;
   localparam int SLOT_W     = $clog2(NUM_ELEMENTS);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ELEMENTS - 1);

   if (AXI_WIDTH % DATA_WIDTH != 0) begin : g_bad_axi_width
      $error("AXI_WIDTH must be a multiple of DATA_WIDTH");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("DATA_WIDTH must be a multiple of 8");
   end
   if (NUM_ELEMENTS < 2) begin : g_bad_num_elements
      $error("NUM_ELEMENTS must be at least 2");
   end
   if (ELEM_BYTES > MAX_ELEM_BYTES) begin : g_bad_elem_bytes
      $error("element wider than the keep expansion helper supports");
   end

   logic [AXI_WIDTH-1:0] asm_data_q, asm_data_d;
   logic [KEEP_W-1:0]    asm_keep_q, asm_keep_d;
   logic                 asm_last_q, asm_last_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic                 pending_q, pending_d;
   logic [AXI_WIDTH-1:0] out_tdata_q, out_tdata_d;
   logic [KEEP_W-1:0]    out_tkeep_q, out_tkeep_d;
   logic                 out_tlast_q, out_tlast_d;
   logic                 out_tvalid_q, out_tvalid_d;

   logic                 accept, drain, complete, out_free;
   logic [AXI_WIDTH-1:0] beat_data;
   logic [KEEP_W-1:0]    beat_keep;

   always_comb begin
      accept   = in_valid && !pending_q;
      drain    = out_tvalid_q && out_tready;
      complete = accept && ((slot_q == LAST_SLOT) || in_last);
      out_free = !out_tvalid_q || drain;

      // Slot 0 starts a fresh beat so unfilled upper slots end up zero.
      beat_data = (slot_q == '0) ? '0 : asm_data_q;
      beat_keep = (slot_q == '0) ? '0 : asm_keep_q;
      beat_data[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
      beat_keep[int'(slot_q)*ELEM_BYTES +: ELEM_BYTES] =
         ELEM_BYTES'(expand_keep(in_keep, ELEM_BYTES));

      asm_data_d   = asm_data_q;
      asm_keep_d   = asm_keep_q;
      asm_last_d   = asm_last_q;
      slot_d       = slot_q;
      pending_d    = pending_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tlast_d  = out_tlast_q;
      out_tvalid_d = out_tvalid_q;

      if (accept) begin
         asm_data_d = beat_data;
         asm_keep_d = beat_keep;
         asm_last_d = in_last;
         slot_d     = complete ? '0 : slot_q + SLOT_W'(1);
      end

      if (drain) out_tvalid_d = 1'b0;

      // A held beat has priority; no element is accepted while it waits.
      if (pending_q && drain) begin
         out_tdata_d  = asm_data_q;
         out_tkeep_d  = asm_keep_q;
         out_tlast_d  = asm_last_q;
         out_tvalid_d = 1'b1;
         pending_d    = 1'b0;
      end else if (complete) begin
         if (out_free) begin
            out_tdata_d  = beat_data;
            out_tkeep_d  = beat_keep;
            out_tlast_d  = in_last;
            out_tvalid_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_data_q   <= '0;
         asm_keep_q   <= '0;
         asm_last_q   <= 1'b0;
         slot_q       <= '0;
         pending_q    <= 1'b0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
      end else begin
         asm_data_q   <= asm_data_d;
         asm_keep_q   <= asm_keep_d;
         asm_last_q   <= asm_last_d;
         slot_q       <= slot_d;
         pending_q    <= pending_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tlast_q  <= out_tlast_d;
         out_tvalid_q <= out_tvalid_d;
      end
   end

   assign in_ready   = !pending_q;
   assign out_tdata  = out_tdata_q;
   assign out_tkeep  = out_tkeep_q;
   assign out_tlast  = out_tlast_q;
   assign out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_data_to_axi_packer.sv
// Scoreboard bench for data_to_axi_packer with 32-bit elements in 128-bit beats:
// directed scenarios plus randomized traffic against a slot-list reference model.
module tb_data_to_axi_packer;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } beat_t;

   logic         clk;
   logic         rst;
   logic [31:0]  in_data;
   logic         in_keep;
   logic         in_last;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_tdata;
   logic [15:0]  out_tkeep;
   logic         out_tlast;
   logic         out_tvalid;
   logic         out_tready;

   int           nCompared;
   int           nMismatched;
   beat_t        expQ[$];
   logic [127:0] mData;
   logic [15:0]  mKeep;
   int           mSlot;
   logic         stallPrev;
   logic [159:0] prevOut;
   logic         randDone;

   data_to_axi_packer #(
      .data_t    (logic [31:0]),
      .AXI_WIDTH (128)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_keep    (in_keep),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_tdata  (out_tdata),
      .out_tkeep  (out_tkeep),
      .out_tlast  (out_tlast),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [159:0] actual,
                              input logic [159:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic applyStimulus(input logic [31:0] d, input logic k, input logic l);
      bit accepted;
      accepted = 0;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      for (int c = 0; c < 200 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) accepted = 1;
      end
      if (!accepted) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int c;
      c = 0;
      while ((expQ.size() != 0 || out_tvalid) && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= 500) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL drain_timeout: %0d beats still expected", expQ.size());
      end
   endtask

   // Reference model: elements fill slots in order; a beat closes on the last slot or on last.
   task automatic monitor();
      beat_t got, exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            mSlot = 0;
            mData = '0;
            mKeep = '0;
            expQ.delete();
            stallPrev = 0;
         end else begin
            if (stallPrev) begin
               checkOutput("hold_valid", 160'(out_tvalid), 160'(1));
               checkOutput("hold_beat", {15'd0, out_tlast, out_tkeep, out_tdata}, prevOut);
            end
            stallPrev = out_tvalid && !out_tready;
            prevOut   = {15'd0, out_tlast, out_tkeep, out_tdata};
            if (in_valid && in_ready) begin
               mData[mSlot*32 +: 32] = in_data;
               mKeep[mSlot*4 +: 4]   = {4{in_keep}};
               mSlot++;
               if (mSlot == 4 || in_last) begin
                  expQ.push_back('{data: mData, keep: mKeep, last: in_last});
                  mSlot = 0;
                  mData = '0;
                  mKeep = '0;
               end
            end
            if (out_tvalid && out_tready) begin
               got = '{data: out_tdata, keep: out_tkeep, last: out_tlast};
               if (expQ.size() == 0) begin
                  nCompared++;
                  nMismatched++;
                  $display("[TB] FAIL unexpected_beat: got tdata=%h tkeep=%h, expected no beat",
                           got.data, got.keep);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("beat_tdata", 160'(got.data), 160'(exp.data));
                  checkOutput("beat_tkeep", 160'(got.keep), 160'(exp.keep));
                  checkOutput("beat_tlast", 160'(got.last), 160'(exp.last));
               end
            end
         end
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      mSlot       = 0;
      mData       = '0;
      mKeep       = '0;
      stallPrev   = 0;
      prevOut     = '0;
      randDone    = 0;
      rst         = 1'b1;
      in_data     = '0;
      in_keep     = 1'b0;
      in_last     = 1'b0;
      in_valid    = 1'b0;
      out_tready  = 1'b1;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_tvalid", 160'(out_tvalid), 160'(0));
      checkOutput("reset_tdata", 160'(out_tdata), 160'(0));
      checkOutput("reset_tkeep", 160'(out_tkeep), 160'(0));
      checkOutput("reset_tlast", 160'(out_tlast), 160'(0));
      checkOutput("reset_in_ready", 160'(in_ready), 160'(1));
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] full beat");
      applyStimulus(32'h11, 1'b1, 1'b0);
      applyStimulus(32'h22, 1'b1, 1'b0);
      applyStimulus(32'h33, 1'b1, 1'b0);
      applyStimulus(32'h44, 1'b1, 1'b1);
      checkOutput("full_latency_tvalid", 160'(out_tvalid), 160'(1));
      checkOutput("full_tdata", 160'(out_tdata),
                  160'(128'h00000044_00000033_00000022_00000011));
      checkOutput("full_tkeep", 160'(out_tkeep), 160'(16'hFFFF));

      $display("[TB] partial beat, keep hole, lone zero-keep last");
      applyStimulus(32'hA, 1'b1, 1'b0);
      applyStimulus(32'hB, 1'b1, 1'b0);
      applyStimulus(32'hC, 1'b1, 1'b1);
      applyStimulus(32'h1, 1'b1, 1'b0);
      applyStimulus(32'h2, 1'b0, 1'b0);
      applyStimulus(32'h3, 1'b1, 1'b0);
      applyStimulus(32'h4, 1'b1, 1'b0);
      applyStimulus(32'h5, 1'b0, 1'b1);
      waitDrain();

      $display("[TB] backpressure");
      out_tready = 1'b0;
      for (int i = 1; i <= 8; i++) applyStimulus(32'h100 + i, 1'b1, 1'b0);
      checkOutput("bp_in_ready_low", 160'(in_ready), 160'(0));
      checkOutput("bp_tvalid", 160'(out_tvalid), 160'(1));
      checkOutput("bp_beat1", 160'(out_tdata),
                  160'(128'h00000104_00000103_00000102_00000101));
      out_tready = 1'b1;
      @(posedge clk);
      #1;
      out_tready = 1'b0;
      checkOutput("bp_release_in_ready", 160'(in_ready), 160'(1));
      checkOutput("bp_beat2_tvalid", 160'(out_tvalid), 160'(1));
      checkOutput("bp_beat2", 160'(out_tdata),
                  160'(128'h00000108_00000107_00000106_00000105));
      out_tready = 1'b1;
      waitDrain();

      $display("[TB] reset mid-beat");
      applyStimulus(32'hDEAD0001, 1'b1, 1'b0);
      applyStimulus(32'hDEAD0002, 1'b1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_tvalid", 160'(out_tvalid), 160'(0));
      checkOutput("midrst_in_ready", 160'(in_ready), 160'(1));
      #6;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) applyStimulus(32'h200 + i, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] randomized traffic");
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               applyStimulus($urandom, ($urandom_range(0, 4) != 0),
                             ($urandom_range(0, 5) == 0));
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            applyStimulus($urandom, 1'b1, 1'b1);
            randDone = 1;
         end
         begin
            while (!randDone) begin
               @(posedge clk);
               #1;
               out_tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_tready = 1'b1;
      waitDrain();
      checkOutput("final_queue_empty", 160'(expQ.size()), 160'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
